regfile_async_rst: RTL and testbench
====================================

# regfile_async_rst

Multi-port register file: an array of DEPTH words of WIDTH bits, with byte-strobed write ports and independent read ports. Every entry resets asynchronously to RESET_VAL. Write-to-read bypass, a hardwired zero entry and a registered-read mode are each selectable by parameter. It sits in the `registers_regfiles` library as the general storage block for CPU register files, CSR banks and configuration shadows.

## Interface
- `WIDTH`, 32, word width in bits; must be a multiple of 8 (elaboration error otherwise)
- `DEPTH`, 32, number of entries, ≥2; need not be a power of two
- `NUM_WR`, 2, number of write ports, ≥1
- `NUM_RD`, 2, number of read ports, ≥1
- `RESET_VAL`, '0, WIDTH-bit value loaded into every entry on reset
- `BYPASS`, 1, 1 = a same-cycle write is visible on reads
- `ZERO_REG`, 0, 1 = entry 0 reads as 0 and ignores writes
- `READ_REG`, 0, 0 = combinational read; 1 = read data registered
- Derived: AW = max(1, $clog2(DEPTH)); SW = WIDTH/8
- Reset and clock (already decided): reset `rst`, asynchronous, active-high; clock `clk`.
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous active-high reset
- `wr_en`  in  [NUM_WR]  write request per port
- `wr_addr`  in  [NUM_WR][AW]  write address
- `wr_strb`  in  [NUM_WR][SW]  byte-lane enables
- `wr_data`  in  [NUM_WR][WIDTH]  write data
- `rd_en`  in  [NUM_RD]  read request; used only when READ_REG=1
- `rd_addr`  in  [NUM_RD][AW]  read address
- `rd_data`  out  [NUM_RD][WIDTH]  read data

## Operation
- **Reset:** on `rst` high, every entry goes to RESET_VAL immediately, independent of `clk`.
  - When READ_REG=1, every `rd_data` resets to RESET_VAL.
  - When READ_REG=0, `rd_data` reflects the reset array through the combinational path.
- **Write:** on a rising edge with `wr_en[p]`=1, byte lane b of entry `wr_addr[p]` takes `wr_data[p]` lane b wherever `wr_strb[p][b]`=1. Lanes with strobe 0 hold their value.
- **Write conflict:** when several ports hit the same entry and lane, the highest port index wins, resolved per lane. Lanes written by only one port take that port's data.
- **Dropped writes:**
  - Any write with `wr_addr` ≥ DEPTH.
  - Any write to address 0 when ZERO_REG=1.
- **Read value:** the entry content, byte-merged with the winning same-cycle writes when BYPASS=1.
  - Reads of address ≥ DEPTH return 0.
  - Reads of address 0 return 0 when ZERO_REG=1.
- **READ_REG=0:** `rd_data` is combinational from `rd_addr`; `rd_en` is ignored.
- **READ_REG=1:**
  - On a rising edge with `rd_en[r]`=1, `rd_data[r]` captures the read value. With BYPASS=1 that value includes the same-edge write.
  - With `rd_en[r]`=0, `rd_data[r]` holds.
- **Reset mid-operation:** a write on the edge coincident with `rst` is lost. A registered read pending on that edge returns RESET_VAL.

## Timing
- Write latency: 1 cycle, entry updated at edge N.
- Read, READ_REG=0:
  - BYPASS=0: combinational, sees writes from edge N onward.
  - BYPASS=1: also sees cycle-N write data before the edge.
- Read, READ_REG=1:
  - Data valid one cycle after `rd_en`.
  - BYPASS=0: a read of an address written on the same edge returns the old value.
  - BYPASS=1: returns the new value.
- No combinational path from `wr_*` to `rd_data` when BYPASS=0 and READ_REG=1.

## Structure
- Package `regfile_pkg`:
  - `regfile_merge` function: lane-wise strobe merge of old and new data.
  - Priority-resolve function: per lane across write ports, highest index wins.
  - Constants for lane width (8).
- One sub-module, `register_en_async_rst`, instantiated once per entry per byte lane.
  - WIDTH=8; RESET_VAL set to the matching slice of the RESET_VAL parameter.
  - `en` = OR over write ports of (address match & strobe & `wr_en`), with the ZERO_REG and range masks applied.
- Read muxes and the bypass merge live in the top level; READ_REG=1 adds one output register per read port.

## Test plan
- **Reset:** RESET_VAL=32'hA5A5_A5A5, assert `rst` mid-cycle → all reads return A5A5_A5A5 before the next edge; READ_REG=1 outputs equal A5A5_A5A5.
- **Strobes and conflict:** entry 3 = 0; port0 writes 0x11223344 with strb 4'b1111 and port1 writes 0xAABBCCDD with strb 4'b0101, both to addr 3 → entry 3 = 0x11BB33DD.
- **Bypass:** BYPASS=1, READ_REG=0, write 0xDEADBEEF to addr 5 while reading addr 5 in the same cycle → `rd_data` = 0xDEADBEEF before the edge. BYPASS=0 → old value.
- **Zero and range:** ZERO_REG=1, DEPTH=20, write 0xFFFF_FFFF to addr 0 and to addr 25 → reads of addr 0 and addr 25 return 0; no other entry changes.
- **Registered read:** READ_REG=1, `rd_en`=1 at addr 7 (holding 0x7), then `rd_en`=0 while addr 7 is rewritten to 0x8 → `rd_data` = 0x7 one cycle later and holds 0x7 until the next `rd_en`.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register file: lane width, write-port limits,
// the per-lane strobe merge and the per-lane write-port priority resolver.
package regfile_pkg;

  localparam int LANE_W     = 8;
  localparam int MAX_WR     = 32;
  localparam int PORT_IDX_W = $clog2(MAX_WR);

  // Result of resolving one byte lane across all write ports.
  typedef struct packed {
    logic                  hit;
    logic [PORT_IDX_W-1:0] idx;
  } lane_sel_t;

  // Strobe merge of one byte lane: new data where the strobe is set, else old.
  function automatic logic [LANE_W-1:0] regfile_merge(
    input logic [LANE_W-1:0] old_lane,
    input logic [LANE_W-1:0] new_lane,
    input logic              strb
  );
    return strb ? new_lane : old_lane;
  endfunction

  // Highest-index port with its hit bit set wins the lane.
  function automatic lane_sel_t regfile_prio(input logic [MAX_WR-1:0] hits);
    lane_sel_t sel;
    sel = '0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (hits[p]) begin
        sel.hit = 1'b1;
        sel.idx = PORT_IDX_W'(p);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/register_en_async_rst.sv
// Enabled register with asynchronous active-high reset; one byte lane of
// one register file entry.
module register_en_async_rst
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = LANE_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on enabled rising edges; reset forces RESET_VAL immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_async_rst.sv
// Multi-port register file with byte-strobed writes, per-lane write priority
// (highest port wins), optional write-to-read bypass, optional hardwired zero
// entry and optional registered reads. All entries reset asynchronously.
module regfile_async_rst
  import regfile_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 32,
  parameter int               NUM_WR    = 2,
  parameter int               NUM_RD    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               BYPASS    = 1,
  parameter int               ZERO_REG  = 0,
  parameter int               READ_REG  = 0,
  localparam int              AW        = (DEPTH > 2) ? $clog2(DEPTH) : 1,
  localparam int              SW        = WIDTH / LANE_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WR-1:0]              wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]      wr_addr,
  input  logic [NUM_WR-1:0][SW-1:0]      wr_strb,
  input  logic [NUM_WR-1:0][WIDTH-1:0]   wr_data,
  input  logic [NUM_RD-1:0]              rd_en,
  input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
  output logic [NUM_RD-1:0][WIDTH-1:0]   rd_data
);

  if (WIDTH % LANE_W != 0) begin : g_bad_width
    $error("regfile_async_rst: WIDTH must be a multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("regfile_async_rst: DEPTH must be at least 2");
  end
  if (NUM_WR < 1 || NUM_WR > MAX_WR) begin : g_bad_wr
    $error("regfile_async_rst: NUM_WR out of range");
  end
  if (NUM_RD < 1) begin : g_bad_rd
    $error("regfile_async_rst: NUM_RD must be at least 1");
  end

  // Per entry, per lane: write enable, resolved write data, stored value and
  // the value a reader sees (stored value merged with same-cycle writes).
  logic [DEPTH-1:0][SW-1:0]             lane_en;
  logic [DEPTH-1:0][SW-1:0][LANE_W-1:0] lane_d;
  logic [DEPTH-1:0][SW-1:0][LANE_W-1:0] lane_q;
  logic [DEPTH-1:0][SW-1:0][LANE_W-1:0] lane_view;

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    for (genvar b = 0; b < SW; b++) begin : g_lane
      // Entry 0 never takes writes when it is the hardwired zero register.
      localparam bit WRITABLE = !(ZERO_REG != 0 && e == 0);

      logic [MAX_WR-1:0] hits;
      lane_sel_t         sel;
      logic [LANE_W-1:0] d_l;

      // Gather which ports write this lane of this entry and pick the winner.
      // Addresses >= DEPTH never match any entry, so such writes are dropped.
      always_comb begin
        hits = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          hits[p] = WRITABLE && wr_en[p] && wr_strb[p][b] && (wr_addr[p] == AW'(e));
        end
        sel = regfile_prio(hits);
        d_l = '0;
        for (int p = 0; p < NUM_WR; p++) begin
          if (sel.idx == PORT_IDX_W'(p)) begin
            d_l = wr_data[p][b*LANE_W +: LANE_W];
          end
        end
      end

      assign lane_en[e][b] = sel.hit;
      assign lane_d[e][b]  = d_l;

      register_en_async_rst #(
        .WIDTH     (LANE_W),
        .RESET_VAL (RESET_VAL[b*LANE_W +: LANE_W])
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .en  (sel.hit),
        .d   (d_l),
        .q   (lane_q[e][b])
      );

      // While reset is held the array is at RESET_VAL and pending writes are
      // lost, so the bypass is suppressed.
      assign lane_view[e][b] = regfile_merge(lane_q[e][b], d_l,
                                             (BYPASS != 0) && sel.hit && !rst);
    end
  end

  // Read value per port: out-of-range addresses and the zero entry read 0.
  logic [NUM_RD-1:0][WIDTH-1:0] rd_val;

  // Address decode for every read port.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (rd_addr[r] == AW'(e) && !(ZERO_REG != 0 && e == 0)) begin
          rd_val[r] = lane_view[e];
        end
      end
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [NUM_RD-1:0][WIDTH-1:0] rd_q;

    // Capture the read value on rd_en, hold otherwise; reset to RESET_VAL.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_q <= {NUM_RD{RESET_VAL}};
      end else begin
        for (int r = 0; r < NUM_RD; r++) begin
          if (rd_en[r]) begin
            rd_q[r] <= rd_val[r];
          end
        end
      end
    end

    assign rd_data = rd_q;
  end else begin : g_rd_comb
    // rd_en has no role with combinational reads.
    logic unused_rd_en;
    assign unused_rd_en = ^rd_en;
    assign rd_data      = rd_val;
  end

endmodule

// File: tb/tb_regfile_async_rst.sv
// Bench for regfile_async_rst. Four instances share one stimulus stream:
//   cfg 0: DEPTH=20, BYPASS=1, ZERO_REG=1, READ_REG=0
//   cfg 1: DEPTH=32, BYPASS=0, ZERO_REG=0, READ_REG=0
//   cfg 2: DEPTH=32, BYPASS=0, ZERO_REG=0, READ_REG=1
//   cfg 3: DEPTH=32, BYPASS=1, ZERO_REG=0, READ_REG=1
// A word-level model tracks each configuration; a compare process checks all
// read outputs every cycle, and directed steps check literal values.
module tb_regfile_async_rst;

  localparam logic [31:0] RV = 32'hA5A5_A5A5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        wr_en   = '0;
  logic [1:0][4:0]   wr_addr = '0;
  logic [1:0][3:0]   wr_strb = '0;
  logic [1:0][31:0]  wr_data = '0;
  logic [1:0]        rd_en   = '0;
  logic [1:0][4:0]   rd_addr = '0;
  logic [1:0][31:0]  rd_a, rd_b, rd_c, rd_d;

  regfile_async_rst #(.WIDTH(32), .DEPTH(20), .NUM_WR(2), .NUM_RD(2), .RESET_VAL(RV),
                      .BYPASS(1), .ZERO_REG(1), .READ_REG(0)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_a));
  regfile_async_rst #(.WIDTH(32), .DEPTH(32), .NUM_WR(2), .NUM_RD(2), .RESET_VAL(RV),
                      .BYPASS(0), .ZERO_REG(0), .READ_REG(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_b));
  regfile_async_rst #(.WIDTH(32), .DEPTH(32), .NUM_WR(2), .NUM_RD(2), .RESET_VAL(RV),
                      .BYPASS(0), .ZERO_REG(0), .READ_REG(1)) dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_c));
  regfile_async_rst #(.WIDTH(32), .DEPTH(32), .NUM_WR(2), .NUM_RD(2), .RESET_VAL(RV),
                      .BYPASS(1), .ZERO_REG(0), .READ_REG(1)) dut_d (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_strb(wr_strb),
    .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_d));

  // ---------------- configuration table ----------------
  function automatic int cfg_depth(input int c);
    return (c == 0) ? 20 : 32;
  endfunction
  function automatic bit cfg_byp(input int c);
    return (c == 0 || c == 3);
  endfunction
  function automatic bit cfg_zero(input int c);
    return (c == 0);
  endfunction
  function automatic bit cfg_rr(input int c);
    return (c >= 2);
  endfunction

  function automatic logic [31:0] get_rd(input int c, input int r);
    case (c)
      0:       return rd_a[r];
      1:       return rd_b[r];
      2:       return rd_c[r];
      default: return rd_d[r];
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] mem [4][32];
  logic [31:0] rq  [4][2];

  // Word after this cycle's writes: ports applied in index order, so a later
  // port overwrites an earlier one lane by lane.
  function automatic logic [31:0] apply_writes(input int c, input logic [4:0] a,
                                               input logic [31:0] v);
    logic [31:0] w;
    w = v;
    if (int'(a) < cfg_depth(c) && !(cfg_zero(c) && a == 5'd0)) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_addr[p] == a) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[p][b]) w[b*8 +: 8] = wr_data[p][b*8 +: 8];
          end
        end
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] model_read(input int c, input logic [4:0] a);
    if (int'(a) >= cfg_depth(c)) return 32'h0;
    if (cfg_zero(c) && a == 5'd0) return 32'h0;
    if (cfg_byp(c) && !rst) return apply_writes(c, a, mem[c][a]);
    return mem[c][a];
  endfunction

  function automatic logic [31:0] model_out(input int c, input int r);
    if (cfg_rr(c)) return rq[c][r];
    return model_read(c, rd_addr[r]);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        for (int a = 0; a < 32; a++) mem[c][a] <= RV;
        for (int r = 0; r < 2; r++) rq[c][r] <= RV;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 2; r++) begin
          if (cfg_rr(c) && rd_en[r]) rq[c][r] <= model_read(c, rd_addr[r]);
        end
        for (int a = 0; a < 32; a++) mem[c][a] <= apply_writes(c, 5'(a), mem[c][a]);
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_on   = 1'b0;

  // Compare every read output against the model, 2 units after the
  // falling edge (inputs settled, rising edge still ahead).
  always @(negedge clk) begin
    #2;
    if (chk_on) begin
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 2; r++) begin
          logic [31:0] exp_v, got_v;
          exp_v = model_out(c, r);
          got_v = get_rd(c, r);
          n_checks++;
          if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL model cfg%0d rd%0d addr=%0d t=%0t got=%h expected=%h",
                     c, r, rd_addr[r], $time, got_v, exp_v);
          end
        end
      end
    end
  end

  task automatic check_lit(input string name, input logic [31:0] got_v,
                           input logic [31:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_errors++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got_v, exp_v);
    end
  endtask

  // ---------------- driver ----------------
  task automatic set_in(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                        input logic [3:0] ws0, input logic [3:0] ws1,
                        input logic [31:0] wd0, input logic [31:0] wd1,
                        input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
    wr_en      = we;
    wr_addr[0] = wa0;  wr_addr[1] = wa1;
    wr_strb[0] = ws0;  wr_strb[1] = ws1;
    wr_data[0] = wd0;  wr_data[1] = wd1;
    rd_en      = re;
    rd_addr[0] = ra0;  rd_addr[1] = ra1;
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                       input logic [3:0] ws0, input logic [3:0] ws1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
    @(negedge clk);
    set_in(we, wa0, wa1, ws0, ws1, wd0, wd1, re, ra0, ra1);
  endtask

  task automatic idle(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
    drive(2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, re, ra0, ra1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (2) @(negedge clk);
    set_in(2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd4);

    // Reset asserted mid-cycle: visible before the next rising edge.
    #3 rst = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 2; r++) check_lit($sformatf("reset cfg%0d rd%0d", c, r), get_rd(c, r), RV);
    end
    chk_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Strobes and per-lane conflict on entry 3.
    drive(2'b01, 5'd3, 5'd0, 4'hF, 4'h0, 32'h0, 32'h0, 2'b00, 5'd3, 5'd3);
    drive(2'b11, 5'd3, 5'd3, 4'hF, 4'h5, 32'h1122_3344, 32'hAABB_CCDD, 2'b00, 5'd3, 5'd3);
    #3;
    check_lit("conflict bypass cfg0", rd_a[0], 32'h11BB_33DD);
    check_lit("conflict no-bypass cfg1", rd_b[0], 32'h0000_0000);
    idle(2'b11, 5'd3, 5'd3);
    #3;
    check_lit("conflict stored cfg0", rd_a[0], 32'h11BB_33DD);
    check_lit("conflict stored cfg1", rd_b[0], 32'h11BB_33DD);
    check_lit("regread before en cfg2", rd_c[0], RV);
    idle(2'b00, 5'd3, 5'd3);
    #3;
    check_lit("conflict regread cfg2", rd_c[0], 32'h11BB_33DD);

    // Same-cycle bypass on entry 5.
    drive(2'b01, 5'd5, 5'd0, 4'hF, 4'h0, 32'hDEAD_BEEF, 32'h0, 2'b11, 5'd5, 5'd5);
    #3;
    check_lit("bypass comb cfg0", rd_a[0], 32'hDEAD_BEEF);
    check_lit("no bypass comb cfg1", rd_b[0], RV);
    idle(2'b00, 5'd5, 5'd5);
    #3;
    check_lit("regread old value cfg2", rd_c[0], RV);
    check_lit("regread bypass cfg3", rd_d[0], 32'hDEAD_BEEF);
    check_lit("after write cfg1", rd_b[0], 32'hDEAD_BEEF);

    // Zero entry and out-of-range address.
    drive(2'b11, 5'd0, 5'd25, 4'hF, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd0, 5'd25);
    #3;
    check_lit("zero reg bypass cfg0", rd_a[0], 32'h0);
    check_lit("range bypass cfg0", rd_a[1], 32'h0);
    check_lit("entry0 old cfg1", rd_b[0], RV);
    idle(2'b00, 5'd0, 5'd25);
    #3;
    check_lit("zero reg cfg0", rd_a[0], 32'h0);
    check_lit("range cfg0", rd_a[1], 32'h0);
    check_lit("entry0 written cfg1", rd_b[0], 32'hFFFF_FFFF);
    check_lit("entry25 written cfg1", rd_b[1], 32'hFFFF_FFFF);

    // Read sweep: the model compare confirms no other entry moved.
    for (int i = 0; i < 32; i++) idle(2'b11, 5'(i), 5'(31 - i));

    // Registered read holds while the entry is rewritten.
    drive(2'b01, 5'd7, 5'd0, 4'hF, 4'h0, 32'h7, 32'h0, 2'b00, 5'd7, 5'd7);
    idle(2'b01, 5'd7, 5'd7);
    drive(2'b01, 5'd7, 5'd0, 4'hF, 4'h0, 32'h8, 32'h0, 2'b00, 5'd7, 5'd7);
    #3;
    check_lit("regread captured cfg2", rd_c[0], 32'h7);
    idle(2'b00, 5'd7, 5'd7);
    #3;
    check_lit("regread holds cfg2", rd_c[0], 32'h7);
    check_lit("regread holds cfg3", rd_d[0], 32'h7);
    check_lit("rewrite visible cfg1", rd_b[0], 32'h8);
    idle(2'b01, 5'd7, 5'd7);
    idle(2'b00, 5'd7, 5'd7);
    #3;
    check_lit("regread refresh cfg2", rd_c[0], 32'h8);

    // Mixed traffic: overlapping ports, partial strobes, varied read enables.
    for (int i = 0; i < 24; i++) begin
      logic [4:0] a0, a1;
      a0 = 5'((i * 7) % 32);
      a1 = (i % 3 == 0) ? a0 : 5'((i * 11 + 1) % 32);
      drive(2'(i % 4), a0, a1, 4'(i % 16), 4'((i * 5) % 16),
            (32'h0101_0101 * 32'(i)) ^ 32'hC300_0000, 32'h5A00_0000 + 32'(i * 3),
            2'((i + 1) % 4), a0, 5'((i * 3) % 32));
    end

    // Reset coincident with a write and a registered read.
    drive(2'b01, 5'd9, 5'd0, 4'hF, 4'h0, 32'h1234_5678, 32'h0, 2'b11, 5'd9, 5'd9);
    #3 rst = 1'b1;
    #1;
    check_lit("reset clears bypass cfg0", rd_a[0], RV);
    check_lit("reset regread cfg2", rd_c[0], RV);
    check_lit("reset regread cfg3", rd_d[0], RV);
    @(negedge clk);
    rst = 1'b0;
    set_in(2'b00, 5'd0, 5'd0, 4'h0, 4'h0, 32'h0, 32'h0, 2'b00, 5'd9, 5'd9);
    #3;
    check_lit("write lost at reset cfg1", rd_b[0], RV);
    check_lit("write lost at reset cfg0", rd_a[0], RV);
    check_lit("regread reset value cfg3", rd_d[1], RV);

    repeat (3) idle(2'b11, 5'd9, 5'd3);
    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
